cmp_flags_pipe: RTL and testbench
=================================

// Module: cmp_flags_pipe
// PURPOSE
//  Pipelined N-bit magnitude comparator producing registered gt/lt/eq flags per operand pair.
//  Resolves CHUNK bits per stage, MSB chunk first, so wide compares close timing at full clock rate.
//  Valid/ready on both sides; sits between synchronised data paths and downstream control logic.
//  Signed or unsigned compare is selected per transaction.
// PARAMETERS
//  N      8  operand width in bits; must be >= 1
//  CHUNK  4  bits resolved per pipeline stage; 1 <= CHUNK <= N
//  STAGES (localparam) = ceil(N/CHUNK); equals the pipeline latency in cycles
// PORTS
//  clk          in   1  single clock; all state on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  in_valid     in   1  operand pair valid
//  in_ready     out  1  block accepts the pair this cycle
//  a            in   N  operand A
//  b            in   N  operand B
//  signed_mode  in   1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
//  out_valid    out  1  result valid
//  out_ready    in   1  downstream accepts the result
//  gt / lt / eq out  1  A>B / A<B / A==B; exactly one is high whenever out_valid=1
// BEHAVIOUR
//  - Reset: every stage valid=0; out_valid, gt, lt, eq = 0; in_ready=1 once rst_n deasserts.
//    Asserting rst_n mid-operation discards all in-flight pairs; no result is emitted for them.
//  - Accept on in_valid&in_ready; emit on out_valid&out_ready. Throughput 1 pair/cycle.
//  - Latency: STAGES cycles from accept to out_valid when there is no backpressure.
//  - Ready chain: ready_k = !valid_k | ready_(k+1); in_ready = ready_0; last stage uses out_ready.
//    A stage holds data, partial state and valid unchanged while stalled. No bubble under steady flow.
//  - Signed: at stage 0, if signed_mode=1, invert the MSB of both A and B. The remaining stages
//    then perform an unsigned compare.
//  - Padding: if N % CHUNK != 0, pad both operands with zeros on the LSB side up to STAGES*CHUNK.
//    The padding does not affect the result.
//  - Per stage, partial state {decided, gt_d}: if !decided and chunk_a != chunk_b, then
//    decided<=1 and gt_d <= (chunk_a > chunk_b). Once decided, later stages pass the state through.
//  - Final stage: gt = decided&gt_d; lt = decided&!gt_d; eq = !decided.
//  - Flags are held stable while out_valid=1 and out_ready=0.
//  - Outside out_valid the flags hold their last value (0 after reset).
// CONFIGURATION
//  CMP_FLAGS_MATCH_CNT_EN defined:
//    - Adds ports match_clr (in, 1) and match_cnt (out, 16).
//    - match_cnt increments on each output handshake with eq=1, saturates at 16'hFFFF, resets to 0.
//    - match_clr zeroes it next cycle; if match_clr coincides with a handshake, the clear wins.
//  Not defined: these ports and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package cmp_flags_pkg:
//    - typedef struct packed {logic decided; logic gt_d;} cmp_part_t;
//    - typedef struct packed {logic gt; logic lt; logic eq;} cmp_result_t;
//    - function cmp_stages(n, chunk) returning ceil(n/chunk).
//  Sub-module cmp_chunk_stage: one registered stage holding chunk compare, partial state and the
//  valid/ready slice; generate-instantiated STAGES times.
// TESTING (N=8, CHUNK=4, STAGES=2)
//  1. Reset: drive rst_n low -> out_valid=0, gt=lt=eq=0. Release rst_n -> in_ready=1.
//  2. Unsigned: a=8'hA5, b=8'h5A, signed_mode=0 -> out_valid 2 cycles later with gt=1.
//     Then a=8'h3C, b=8'h3C -> eq=1.
//  3. Signed: a=8'h80, b=8'h01, signed_mode=1 -> lt=1. Same pair with signed_mode=0 -> gt=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles while streaming 4 pairs.
//     -> in_ready drops after 2 accepts, no pair lost. Release -> results in order, 1 per cycle.
//  5. Reset mid-flight: pulse rst_n low with 2 pairs in flight -> no out_valid for them afterwards.
//  6. N=7, CHUNK=4 with a=7'h40, b=7'h3F -> gt=1 (padding check).
//     With macro defined: 3 eq handshakes -> match_cnt=3; match_clr -> 0.

Source files
------------

// File: rtl/cmp_flags_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
package cmp_flags_pkg;

    typedef struct packed {
        logic decided;
        logic gt_d;
    } cmp_part_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_result_t;

    // Number of CHUNK-wide slices needed to cover n bits (ceiling division).
    function automatic int cmp_stages(input int n, input int chunk);
        return (n + chunk - 1) / chunk;
    endfunction

    // Turn the final partial state into one-hot gt/lt/eq flags.
    function automatic cmp_result_t cmp_decode(input cmp_part_t part);
        cmp_result_t res;
        res.gt = part.decided & part.gt_d;
        res.lt = part.decided & ~part.gt_d;
        res.eq = ~part.decided;
        return res;
    endfunction

endpackage

// File: rtl/cmp_chunk_stage.sv
// One registered comparator stage: compares the CHUNK-wide slice at LSB,
// updates the {decided, gt_d} partial state and carries both operands on
// for the lower-order stages. Holds everything while stalled.
module cmp_chunk_stage
    import cmp_flags_pkg::*;
#(
    parameter int W     = 8,
    parameter int CHUNK = 4,
    parameter int LSB   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_a,
    input  logic [W-1:0] up_b,
    input  logic [1:0]   up_part,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_a,
    output logic [W-1:0] dn_b,
    output logic [1:0]   dn_part,
    output logic [1:0]   part_nxt
);

    logic             valid_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    cmp_part_t        part_r;
    cmp_part_t        part_in_s;
    cmp_part_t        part_nxt_s;
    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic             load_s;

    assign chunk_a_s = up_a[LSB +: CHUNK];
    assign chunk_b_s = up_b[LSB +: CHUNK];
    assign up_ready  = !valid_r || dn_ready;
    assign load_s    = up_valid && up_ready;

    // First differing chunk (MSB side first) decides; later chunks pass the decision through.
    always_comb begin
        part_in_s  = cmp_part_t'(up_part);
        part_nxt_s = part_in_s;
        if (!part_in_s.decided && (chunk_a_s != chunk_b_s)) begin
            part_nxt_s.decided = 1'b1;
            part_nxt_s.gt_d    = (chunk_a_s > chunk_b_s);
        end else begin
            part_nxt_s = part_in_s;
        end
    end

    // Stage register: refill or drain when ready, otherwise hold contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            part_r  <= '0;
        end else begin
            if (up_ready) begin
                valid_r <= up_valid;
            end else begin
                valid_r <= valid_r;
            end
            if (load_s) begin
                a_r    <= up_a;
                b_r    <= up_b;
                part_r <= part_nxt_s;
            end else begin
                a_r    <= a_r;
                b_r    <= b_r;
                part_r <= part_r;
            end
        end
    end

    assign dn_valid = valid_r;
    assign dn_a     = a_r;
    assign dn_b     = b_r;
    assign dn_part  = part_r;
    assign part_nxt = part_nxt_s;

endmodule

// File: rtl/cmp_flags_pipe.sv
// Pipelined N-bit magnitude comparator with registered gt/lt/eq flags.
// CHUNK bits are resolved per stage, MSB chunk first; latency is
// ceil(N/CHUNK) cycles. Optional eq-match counter: CMP_FLAGS_MATCH_CNT_EN.
module cmp_flags_pipe
    import cmp_flags_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         gt,
    output logic         lt,
    output logic         eq
`ifdef CMP_FLAGS_MATCH_CNT_EN
    ,
    input  logic         match_clr,
    output logic [15:0]  match_cnt
`endif
);

    localparam int STAGES = cmp_stages(N, CHUNK);
    localparam int W      = STAGES * CHUNK;
    localparam int PAD    = W - N;

    logic [N-1:0]            a_adj_s;
    logic [N-1:0]            b_adj_s;
    logic [W-1:0]            a_pad_s;
    logic [W-1:0]            b_pad_s;
    logic [(STAGES+1)*W-1:0] a_pipe_s;
    logic [(STAGES+1)*W-1:0] b_pipe_s;
    logic [(STAGES+1)*2-1:0] part_pipe_s;
    logic [STAGES*2-1:0]     nxt_flat_s;
    logic [STAGES:0]         valid_pipe_s;
    logic [STAGES:0]         ready_pipe_s;
    logic                    last_load_s;
    cmp_result_t             flags_r;
    logic                    unused_s;

    // Flipping the sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_adj_s        = a;
        b_adj_s        = b;
        a_adj_s[N-1]   = a[N-1] ^ signed_mode;
        b_adj_s[N-1]   = b[N-1] ^ signed_mode;
    end

    // Zero padding on the LSB side keeps chunk boundaries aligned to the MSB.
    assign a_pad_s = W'(a_adj_s) << PAD;
    assign b_pad_s = W'(b_adj_s) << PAD;

    assign a_pipe_s[W-1:0]         = a_pad_s;
    assign b_pipe_s[W-1:0]         = b_pad_s;
    assign part_pipe_s[1:0]        = 2'b00;
    assign valid_pipe_s[0]         = in_valid;
    assign ready_pipe_s[STAGES]    = out_ready;
    assign in_ready                = ready_pipe_s[0];
    assign out_valid               = valid_pipe_s[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cmp_chunk_stage #(
            .W     (W),
            .CHUNK (CHUNK),
            .LSB   ((STAGES - 1 - k) * CHUNK)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid_pipe_s[k]),
            .up_ready (ready_pipe_s[k]),
            .up_a     (a_pipe_s[k*W +: W]),
            .up_b     (b_pipe_s[k*W +: W]),
            .up_part  (part_pipe_s[k*2 +: 2]),
            .dn_valid (valid_pipe_s[k+1]),
            .dn_ready (ready_pipe_s[k+1]),
            .dn_a     (a_pipe_s[(k+1)*W +: W]),
            .dn_b     (b_pipe_s[(k+1)*W +: W]),
            .dn_part  (part_pipe_s[(k+1)*2 +: 2]),
            .part_nxt (nxt_flat_s[k*2 +: 2])
        );
    end

    // Operand copies and partial state leaving the last stage have no consumer.
    assign unused_s = ^{a_pipe_s[STAGES*W +: W], b_pipe_s[STAGES*W +: W],
                        part_pipe_s[STAGES*2 +: 2], nxt_flat_s};

    assign last_load_s = valid_pipe_s[STAGES-1] && ready_pipe_s[STAGES-1];

    // Flag register loads alongside the last stage so flags stay 0 until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else if (last_load_s) begin
            flags_r <= cmp_decode(cmp_part_t'(nxt_flat_s[(STAGES-1)*2 +: 2]));
        end else begin
            flags_r <= flags_r;
        end
    end

    assign gt = flags_r.gt;
    assign lt = flags_r.lt;
    assign eq = flags_r.eq;

`ifdef CMP_FLAGS_MATCH_CNT_EN
    logic [15:0] match_cnt_r;

    // Saturating count of equal results handed downstream; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_r <= 16'd0;
        end else if (match_clr) begin
            match_cnt_r <= 16'd0;
        end else if (out_valid && out_ready && flags_r.eq && (match_cnt_r != 16'hFFFF)) begin
            match_cnt_r <= match_cnt_r + 16'd1;
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign match_cnt = match_cnt_r;
`endif

endmodule

// File: tb/tb_cmp_flags_pipe.sv
// Directed bench for cmp_flags_pipe (N=8/CHUNK=4 and N=7/CHUNK=4 instances).
module tb_cmp_flags_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [7:0] a, b;
    logic       gt, lt, eq;
    logic [2:0] flags;
    assign flags = {gt, lt, eq};

    logic       in_valid7, in_ready7, sm7, out_valid7;
    logic [6:0] a7, b7;
    logic       gt7, lt7, eq7;
    logic [2:0] flags7;
    assign flags7 = {gt7, lt7, eq7};

`ifdef CMP_FLAGS_MATCH_CNT_EN
    logic        match_clr, match_clr7;
    logic [15:0] match_cnt, match_cnt7;
`endif

    int checks = 0;
    int errors = 0;

    cmp_flags_pipe #(.N(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .gt(gt), .lt(lt), .eq(eq)
`ifdef CMP_FLAGS_MATCH_CNT_EN
        , .match_clr(match_clr), .match_cnt(match_cnt)
`endif
    );

    cmp_flags_pipe #(.N(7), .CHUNK(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
        .a(a7), .b(b7), .signed_mode(sm7), .out_valid(out_valid7),
        .out_ready(1'b1), .gt(gt7), .lt(lt7), .eq(eq7)
`ifdef CMP_FLAGS_MATCH_CNT_EN
        , .match_clr(match_clr7), .match_cnt(match_cnt7)
`endif
    );

    // Present one pair to the 8-bit DUT and complete its handshake.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        bit rdy = 0;
        @(posedge clk); #1;
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid rises (bounded).
    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0; ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; signed_mode = 1'b0;
        a = 8'h00; b = 8'h00; in_valid7 = 1'b0; a7 = 7'h00; b7 = 7'h00; sm7 = 1'b0;
`ifdef CMP_FLAGS_MATCH_CNT_EN
        match_clr = 1'b0; match_clr7 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", flags); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (flags !== 3'b000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rel_idle flags=%b ov=%b exp=000/0", flags, out_valid);
        end
    endtask

    task automatic test_unsigned();
        int cyc; bit ok;
        send(8'hA5, 8'h5A, 1'b0);
        wait_out(cyc, ok);
        checks++;
        if (!ok || cyc != 2) begin errors++; $display("FAIL uns_latency got=%0d ok=%0d exp=2", cyc, ok); end
        checks++;
        if (flags !== 3'b100) begin errors++; $display("FAIL uns_gt got=%b exp=100", flags); end
        send(8'h3C, 8'h3C, 1'b0);
        wait_out(cyc, ok);
        checks++;
        if (!ok || flags !== 3'b001) begin errors++; $display("FAIL uns_eq got=%b ok=%0d exp=001", flags, ok); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || flags !== 3'b001) begin
            errors++; $display("FAIL flag_hold ov=%b flags=%b exp=0/001", out_valid, flags);
        end
    endtask

    task automatic test_signed();
        int cyc; bit ok;
        send(8'h80, 8'h01, 1'b1);
        wait_out(cyc, ok);
        checks++;
        if (!ok || flags !== 3'b010) begin errors++; $display("FAIL sgn_lt got=%b ok=%0d exp=010", flags, ok); end
        send(8'h80, 8'h01, 1'b0);
        wait_out(cyc, ok);
        checks++;
        if (!ok || flags !== 3'b100) begin errors++; $display("FAIL sgn_off_gt got=%b ok=%0d exp=100", flags, ok); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pa [4] = '{8'h10, 8'h20, 8'h33, 8'hFF};
        logic [7:0] pb [4] = '{8'h20, 8'h10, 8'h33, 8'h00};
        logic [2:0] pe [4] = '{3'b010, 3'b100, 3'b001, 3'b100};
        int idx = 0, r = 0, first = -1, last = -1, stall_bad = 0;
        bit take;
        @(posedge clk); #1;
        out_ready = 1'b0; signed_mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) begin a = pa[idx]; b = pb[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            take = in_valid && in_ready;
            if (out_valid && flags !== pe[0]) stall_bad++;
            @(posedge clk); #1;
            if (take) idx++;
        end
        @(negedge clk);
        checks++;
        if (idx != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || flags !== pe[0] || stall_bad != 0) begin
            errors++; $display("FAIL bp_hold ov=%b flags=%b bad=%0d exp=1/%b/0", out_valid, flags, stall_bad, pe[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && r < 4; c++) begin
            if (idx < 4) begin a = pa[idx]; b = pb[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            take = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (flags !== pe[r]) begin errors++; $display("FAIL bp_result%0d got=%b exp=%b", r, flags, pe[r]); end
                if (r == 0) first = c;
                last = c;
                r++;
            end
            @(posedge clk); #1;
            if (take) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (r != 4 || idx != 4) begin errors++; $display("FAIL bp_count results=%0d accepts=%0d exp=4/4", r, idx); end
        checks++;
        if (last - first != 3) begin errors++; $display("FAIL bp_rate span=%0d exp=3", last - first); end
    endtask

    task automatic test_reset_midflight();
        int hits = 0;
        @(posedge clk); #1;
        out_ready = 1'b0; a = 8'h11; b = 8'h22; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h44; b = 8'h44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight ov=%b exp=1", out_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        checks++;
        if (hits != 0) begin errors++; $display("FAIL mid_discard out_valid_cycles=%0d exp=0", hits); end
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL mid_flags got=%b exp=000", flags); end
    endtask

    task automatic test_padding();
        logic [6:0] pa [2] = '{7'h40, 7'h40};
        logic [6:0] pb [2] = '{7'h3F, 7'h3F};
        logic       ps [2] = '{1'b0, 1'b1};
        logic [2:0] pe [2] = '{3'b100, 3'b010};
        for (int t = 0; t < 2; t++) begin
            bit ok = 0;
            @(posedge clk); #1;
            a7 = pa[t]; b7 = pb[t]; sm7 = ps[t]; in_valid7 = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready7 !== 1'b1) begin errors++; $display("FAIL pad_ready%0d got=%b exp=1", t, in_ready7); end
            @(posedge clk); #1;
            in_valid7 = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk);
                if (out_valid7) ok = 1;
            end
            checks++;
            if (!ok || flags7 !== pe[t]) begin
                errors++; $display("FAIL pad_cmp%0d got=%b ok=%0d exp=%b", t, flags7, ok, pe[t]);
            end
        end
    endtask

`ifdef CMP_FLAGS_MATCH_CNT_EN
    task automatic test_match_cnt();
        int cyc; bit ok;
        @(posedge clk); #1 match_clr = 1'b1;
        @(posedge clk); #1 match_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (match_cnt !== 16'd0) begin errors++; $display("FAIL mc_clr0 got=%0d exp=0", match_cnt); end
        for (int i = 0; i < 3; i++) begin
            send(8'h5A, 8'h5A, 1'b0);
            wait_out(cyc, ok);
        end
        send(8'h01, 8'h02, 1'b0);
        wait_out(cyc, ok);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (match_cnt !== 16'd3) begin errors++; $display("FAIL mc_count got=%0d exp=3", match_cnt); end
        @(posedge clk); #1 match_clr = 1'b1;
        @(posedge clk); #1 match_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (match_cnt !== 16'd0) begin errors++; $display("FAIL mc_clr got=%0d exp=0", match_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_midflight();
        test_padding();
`ifdef CMP_FLAGS_MATCH_CNT_EN
        test_match_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
